// File: rtl/alu_arbitro_if.sv
// Command and response bundle shared by the two requesters, the alu_arbitro controller and the
// response consumer. The controller connects through the slave modport, the requester/consumer side through master.
interface alu_arbitro_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [2:0]  req0_op;
    logic [7:0]  req0_a;
    logic [7:0]  req0_b;

    logic        req1_valid;
    logic        req1_ready;
    logic [2:0]  req1_op;
    logic [7:0]  req1_a;
    logic [7:0]  req1_b;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_resultado;
    logic        rsp_banderaA;
    logic        rsp_banderaB;
    logic        rsp_err;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_resultado, rsp_banderaA, rsp_banderaB, rsp_err
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_resultado, rsp_banderaA, rsp_banderaB, rsp_err
    );
endinterface

// File: rtl/alu_arbitro.sv
// Round-robin controller sharing one 8-bit combinational ALU between two requesters, with a multicycle
// execute window and a valid/ready response channel. Define ALU_ARBITRO_STATS_EN to add per-requester response counters.

// Combinational ALU. banderaA = carry / borrow / product overflow, banderaB = zero result.
module alu_arbitro_alu (
    input  logic [2:0]  op_i,
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] resultado_o,
    output logic        banderaA_o,
    output logic        banderaB_o
);
    logic [15:0] res;
    logic        flag_a;

    always_comb begin
        res    = 16'h0000;
        flag_a = 1'b0;
        case (op_i)
            3'b000: begin
                res    = 16'(a_i) + 16'(b_i);
                flag_a = res[8];
            end
            3'b001: begin
                res    = {8'h00, a_i - b_i};
                flag_a = (a_i < b_i);
            end
            3'b010: begin
                res    = 16'(a_i) * 16'(b_i);
                flag_a = |res[15:8];
            end
            // Zero divisor yields 0 here; the controller substitutes its own error result.
            3'b011: if (b_i != 8'h00) res = {8'h00, a_i / b_i};
            3'b100: if (b_i != 8'h00) res = {8'h00, a_i % b_i};
            3'b101: res = {8'h00, a_i & b_i};
            3'b110: res = {8'h00, a_i | b_i};
            default: res = {8'h00, a_i ^ b_i};
        endcase
    end

    assign resultado_o = res;
    assign banderaA_o  = flag_a;
    assign banderaB_o  = (res == 16'h0000);
endmodule

module alu_arbitro #(
    parameter int unsigned RR_INIT     = 0,
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbitro_if.slave  bus,
    output logic          busy
`ifdef ALU_ARBITRO_STATS_EN
    ,
    output logic [15:0]   stat_cnt0,
    output logic [15:0]   stat_cnt1
`endif
);
    if (EXEC_CYCLES < 1 || EXEC_CYCLES > 15) begin : g_bad_exec_cycles
        $error("alu_arbitro: EXEC_CYCLES must be in 1..15");
    end
    if (RR_INIT > 1) begin : g_bad_rr_init
        $error("alu_arbitro: RR_INIT must be 0 or 1");
    end

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);
    localparam logic       PTR_INIT = (RR_INIT != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        id_q, id_d;
    logic [2:0]  op_q, op_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;

    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [15:0] rsp_res_q, rsp_res_d;
    logic        rsp_fa_q, rsp_fa_d;
    logic        rsp_fb_q, rsp_fb_d;
    logic        rsp_err_q, rsp_err_d;

    logic        grant0, grant1;
    logic        div_zero;
    logic [15:0] alu_res;
    logic        alu_fa, alu_fb;

    alu_arbitro_alu u_alu (
        .op_i        (op_q),
        .a_i         (a_q),
        .b_i         (b_q),
        .resultado_o (alu_res),
        .banderaA_o  (alu_fa),
        .banderaB_o  (alu_fb)
    );

    // Grants are offered only in IDLE and never while reset is held.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == S_IDLE && rst_n) begin
            grant0 = bus.req0_valid && (!bus.req1_valid || !ptr_q);
            grant1 = bus.req1_valid && (!bus.req0_valid ||  ptr_q);
        end
    end

    assign div_zero = ((op_q == 3'b011) || (op_q == 3'b100)) && (b_q == 8'h00);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_res_d   = rsp_res_q;
        rsp_fa_d    = rsp_fa_q;
        rsp_fb_d    = rsp_fb_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (grant0 || grant1) begin
                    id_d    = grant1;
                    op_d    = grant1 ? bus.req1_op : bus.req0_op;
                    a_d     = grant1 ? bus.req1_a  : bus.req0_a;
                    b_d     = grant1 ? bus.req1_b  : bus.req0_b;
                    ptr_d   = !grant1;
                    cnt_d   = CNT_LOAD;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q == 4'd0) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_res_d   = div_zero ? 16'hFFFF : alu_res;
                    rsp_fa_d    = div_zero ? 1'b0 : alu_fa;
                    rsp_fb_d    = div_zero ? 1'b0 : alu_fb;
                    rsp_err_d   = div_zero;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                // Returning to IDLE here means the earliest next acceptance is one edge later.
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= PTR_INIT;
            cnt_q       <= 4'd0;
            id_q        <= 1'b0;
            op_q        <= 3'd0;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_res_q   <= 16'h0000;
            rsp_fa_q    <= 1'b0;
            rsp_fb_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_res_q   <= rsp_res_d;
            rsp_fa_q    <= rsp_fa_d;
            rsp_fb_q    <= rsp_fb_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req0_ready    = grant0;
    assign bus.req1_ready    = grant1;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_id        = rsp_id_q;
    assign bus.rsp_resultado = rsp_res_q;
    assign bus.rsp_banderaA  = rsp_fa_q;
    assign bus.rsp_banderaB  = rsp_fb_q;
    assign bus.rsp_err       = rsp_err_q;
    assign busy              = (state_q != S_IDLE);

`ifdef ALU_ARBITRO_STATS_EN
    logic        rsp_hs;
    logic [15:0] stat0_q, stat0_d;
    logic [15:0] stat1_q, stat1_d;

    assign rsp_hs = (state_q == S_RESP) && bus.rsp_ready;

    always_comb begin
        stat0_d = stat0_q;
        stat1_d = stat1_q;
        if (rsp_hs && !rsp_id_q && (stat0_q != 16'hFFFF)) stat0_d = stat0_q + 16'd1;
        if (rsp_hs &&  rsp_id_q && (stat1_q != 16'hFFFF)) stat1_d = stat1_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat0_q <= 16'h0000;
            stat1_q <= 16'h0000;
        end else begin
            stat0_q <= stat0_d;
            stat1_q <= stat1_d;
        end
    end

    assign stat_cnt0 = stat0_q;
    assign stat_cnt1 = stat1_q;
`endif
endmodule
